// File: rtl/kmer_variant_generator.sv
// Multi-lane k-mer substitution generator: issues the original window plus every single-base
// substitution, matches in-order query results to tags, emits solid candidates. Optional: KMER_QUALITY_GATE_EN.
module kmer_variant_lane #(
  parameter int KBW  = 6,
  parameter int KMAX = 64
) (
  input  logic              en,
  input  logic [2*KMAX-1:0] win,
  input  logic              orig_i,
  input  logic [KMAX-1:0]   mask_i,
  input  logic [1:0]        alt_i,
  output logic              vld,
  output logic [2*KMAX-1:0] kmer,
  output logic [KBW+2:0]    tag,
  output logic              orig_o,
  output logic [KMAX-1:0]   mask_o,
  output logic [1:0]        alt_o
);
  logic [KBW-1:0] pos;
  logic [1:0]     nb;

  always_comb begin
    pos = '0;
    for (int i = KMAX - 1; i >= 0; i--) begin
      if (mask_i[i]) pos = KBW'(i);
    end
    nb     = win[2*pos +: 2] + alt_i;
    vld    = 1'b0;
    kmer   = '0;
    tag    = '0;
    orig_o = orig_i;
    mask_o = mask_i;
    alt_o  = alt_i;
    if (en) begin
      if (orig_i) begin
        vld    = 1'b1;
        kmer   = win;
        tag    = {1'b1, {KBW{1'b0}}, 2'b00};
        orig_o = 1'b0;
      end else if (|mask_i) begin
        vld              = 1'b1;
        kmer             = win;
        kmer[2*pos +: 2] = nb;
        tag              = {1'b0, pos, nb};
        // alt walks 1..3; the position retires once its third substitution goes out
        if (alt_i == 2'd3) begin
          alt_o       = 2'd1;
          mask_o[pos] = 1'b0;
        end else begin
          alt_o = alt_i + 2'd1;
        end
      end
    end
  end
endmodule

module kmer_variant_generator #(
  parameter int MAX_READ_BIT_WIDTH = 8,
  parameter int MAX_KMER_BIT_WIDTH = 6,
  parameter int MAX_READ_WIDTH     = 2**MAX_READ_BIT_WIDTH,
  parameter int MAX_KMER_WIDTH     = 2**MAX_KMER_BIT_WIDTH,
  parameter int QUALITY_WIDTH      = 2,
  parameter int LANES              = 2,
  parameter int TAG_DEPTH          = 16
) (
  input  logic                                  clk,
  input  logic                                  rstb,
  input  logic [2*MAX_READ_WIDTH-1:0]           read,
  input  logic [QUALITY_WIDTH*MAX_READ_WIDTH-1:0] quality,
  input  logic [MAX_KMER_BIT_WIDTH-1:0]         kmerLength,
  input  logic [MAX_READ_BIT_WIDTH-1:0]         kmerOffset,
  input  logic [QUALITY_WIDTH-1:0]              qualityThreshold,
  input  logic                                  readValid,
  output logic                                  ready4Read,
  output logic [LANES*2*MAX_KMER_WIDTH-1:0]     kmer,
  output logic [LANES-1:0]                      kmerValid,
  input  logic                                  ready4Kmer,
  input  logic                                  queryResultValid,
  input  logic                                  queryResult,
  output logic                                  ready4Result,
  output logic [2*MAX_READ_WIDTH-1:0]           candidate,
  output logic [MAX_READ_BIT_WIDTH-1:0]         candidatePosition,
  output logic                                  candidateValid,
  input  logic                                  ready4Candidate,
  output logic                                  done,
  output logic                                  solidOriginal,
  output logic [MAX_KMER_BIT_WIDTH+1:0]         candidateCount,
  output logic                                  windowError
);
  localparam int KW    = 2 * MAX_KMER_WIDTH;
  localparam int RW2   = 2 * MAX_READ_WIDTH;
  localparam int QWW   = QUALITY_WIDTH * MAX_KMER_WIDTH;
  localparam int KBW   = MAX_KMER_BIT_WIDTH;
  localparam int RBW   = MAX_READ_BIT_WIDTH;
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CC_W  = KBW + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;
  typedef struct packed {
    logic           orig;
    logic [KBW-1:0] pos;
    logic [1:0]     base;
  } tag_t;

  state_t                  state_q, state_d;
  logic [RW2-1:0]          read_q, read_d;
  logic [KW-1:0]           win_q, win_d;
  logic [RBW-1:0]          offset_q, offset_d;
  logic [MAX_KMER_WIDTH-1:0] mask_q, mask_d;
  logic [1:0]              alt_q, alt_d;
  logic                    orig_q, orig_d;
  tag_t                    tag_mem_q [TAG_DEPTH];
  tag_t                    tag_mem_d [TAG_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [RW2-1:0]          cand_q, cand_d;
  logic [RBW-1:0]          cand_pos_q, cand_pos_d;
  logic                    cand_vld_q, cand_vld_d;
  logic [CC_W-1:0]         cand_cnt_q, cand_cnt_d;
  logic                    solid_orig_q, solid_orig_d;
  logic                    win_err_q, win_err_d;

  // Lane chain: each lane consumes the cursor left by the lane below it
  logic [LANES:0]                         c_orig;
  logic [LANES:0][MAX_KMER_WIDTH-1:0]     c_mask;
  logic [LANES:0][1:0]                    c_alt;
  logic [LANES-1:0]                       lane_vld;
  logic [LANES-1:0][KW-1:0]               lane_kmer;
  tag_t [LANES-1:0]                       lane_tag;
  logic                                   issue_en;

  assign issue_en  = (state_q == ISSUE) && (count_q <= CNT_W'(TAG_DEPTH - LANES));
  assign c_orig[0] = orig_q;
  assign c_mask[0] = mask_q;
  assign c_alt[0]  = alt_q;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    kmer_variant_lane #(.KBW(KBW), .KMAX(MAX_KMER_WIDTH)) u_lane (
      .en     (issue_en),
      .win    (win_q),
      .orig_i (c_orig[j]),
      .mask_i (c_mask[j]),
      .alt_i  (c_alt[j]),
      .vld    (lane_vld[j]),
      .kmer   (lane_kmer[j]),
      .tag    (lane_tag[j]),
      .orig_o (c_orig[j+1]),
      .mask_o (c_mask[j+1]),
      .alt_o  (c_alt[j+1])
    );
  end

  logic                  kmer_fire, res_fire, pop, bad_win;
  logic [CNT_W-1:0]      n_push;
  logic [RBW:0]          win_end;
  logic [KW-1:0]         win_raw, len_mask;
  logic [MAX_KMER_WIDTH-1:0] elig;
  logic [RBW-1:0]        pos_sum;
  tag_t                  head;

  assign kmer_fire = ready4Kmer & (|lane_vld);
  assign res_fire  = queryResultValid & ready4Result;
  assign pop       = res_fire & (count_q != '0);
  assign head      = tag_mem_q[rd_ptr_q];
  assign pos_sum   = offset_q + RBW'(head.pos);
  assign win_end   = {1'b0, kmerOffset} + (RBW+1)'(kmerLength);
  assign bad_win   = (kmerLength == '0) || (win_end > (RBW+1)'(MAX_READ_WIDTH));
  assign win_raw   = KW'(read >> (2 * kmerOffset));

`ifdef KMER_QUALITY_GATE_EN
  logic [QWW-1:0] qwin;
  assign qwin = QWW'(quality >> (QUALITY_WIDTH * kmerOffset));
`else
  logic unused_gate_inputs;
  assign unused_gate_inputs = ^{quality, qualityThreshold};
`endif

  always_comb begin
    len_mask = '0;
    elig     = '0;
    for (int b = 0; b < MAX_KMER_WIDTH; b++) begin
      len_mask[2*b +: 2] = {2{KBW'(b) < kmerLength}};
`ifdef KMER_QUALITY_GATE_EN
      elig[b] = (KBW'(b) < kmerLength) && (qwin[QUALITY_WIDTH*b +: QUALITY_WIDTH] < qualityThreshold);
`else
      elig[b] = KBW'(b) < kmerLength;
`endif
    end
  end

  always_comb begin
    n_push = '0;
    for (int j = 0; j < LANES; j++) n_push = n_push + CNT_W'(lane_vld[j]);
  end

  always_comb begin
    state_d      = state_q;
    read_d       = read_q;
    win_d        = win_q;
    offset_d     = offset_q;
    mask_d       = mask_q;
    alt_d        = alt_q;
    orig_d       = orig_q;
    tag_mem_d    = tag_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q + (kmer_fire ? n_push : '0) - CNT_W'(pop);
    cand_d       = cand_q;
    cand_pos_d   = cand_pos_q;
    cand_vld_d   = cand_vld_q;
    cand_cnt_d   = cand_cnt_q;
    solid_orig_d = solid_orig_q;
    win_err_d    = win_err_q;

    case (state_q)
      IDLE: begin
        if (readValid) begin
          read_d       = read;
          win_d        = win_raw & len_mask;
          offset_d     = kmerOffset;
          alt_d        = 2'd1;
          cand_cnt_d   = '0;
          solid_orig_d = 1'b0;
          win_err_d    = bad_win;
          orig_d       = !bad_win;
          mask_d       = bad_win ? '0 : elig;
          state_d      = bad_win ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        if (kmer_fire) begin
          orig_d = c_orig[LANES];
          mask_d = c_mask[LANES];
          alt_d  = c_alt[LANES];
          if (!c_orig[LANES] && c_mask[LANES] == '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (count_q == '0 && !cand_vld_q) state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (kmer_fire) begin
      for (int j = 0; j < LANES; j++) begin
        if (lane_vld[j]) tag_mem_d[wr_ptr_q + PTR_W'(j)] = lane_tag[j];
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
    end

    if (cand_vld_q && ready4Candidate) cand_vld_d = 1'b0;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (head.orig) begin
        solid_orig_d = queryResult;
      end else if (queryResult) begin
        cand_d                  = read_q;
        cand_d[2*pos_sum +: 2]  = head.base;
        cand_pos_d              = pos_sum;
        cand_vld_d              = 1'b1;
        cand_cnt_d              = cand_cnt_q + CC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q      <= IDLE;
      read_q       <= '0;
      win_q        <= '0;
      offset_q     <= '0;
      mask_q       <= '0;
      alt_q        <= 2'd1;
      orig_q       <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cand_q       <= '0;
      cand_pos_q   <= '0;
      cand_vld_q   <= 1'b0;
      cand_cnt_q   <= '0;
      solid_orig_q <= 1'b0;
      win_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      win_q        <= win_d;
      offset_q     <= offset_d;
      mask_q       <= mask_d;
      alt_q        <= alt_d;
      orig_q       <= orig_d;
      tag_mem_q    <= tag_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cand_q       <= cand_d;
      cand_pos_q   <= cand_pos_d;
      cand_vld_q   <= cand_vld_d;
      cand_cnt_q   <= cand_cnt_d;
      solid_orig_q <= solid_orig_d;
      win_err_q    <= win_err_d;
    end
  end

  assign ready4Read        = (state_q == IDLE) && !rstb;
  assign kmer              = lane_kmer;
  assign kmerValid         = lane_vld;
  assign ready4Result      = !cand_vld_q;
  assign candidate         = cand_q;
  assign candidatePosition = cand_pos_q;
  assign candidateValid    = cand_vld_q;
  assign done              = (state_q == FINISH);
  assign solidOriginal     = solid_orig_q;
  assign candidateCount    = cand_cnt_q;
  assign windowError       = win_err_q;
endmodule

// File: tb/tb_kmer_variant_generator.sv
// Scoreboard bench for kmer_variant_generator: expected variants queued per read, results and
// candidates queued as groups and results are accepted, all compared as the DUT hands them over.
module tb_kmer_variant_generator;
  localparam int RBW = 8, KBW = 6, RW = 256, KMW = 64, QW = 2, L = 2, TD = 16;
  localparam int KW = 2 * KMW;

  logic clk = 1'b0, rstb = 1'b1;
  logic [2*RW-1:0]  read = '0;
  logic [QW*RW-1:0] quality = '0;
  logic [KBW-1:0]   kmerLength = '0;
  logic [RBW-1:0]   kmerOffset = '0;
  logic [QW-1:0]    qualityThreshold = '0;
  logic readValid = 1'b0, ready4Kmer = 1'b0, queryResultValid = 1'b0, queryResult = 1'b0;
  logic ready4Candidate = 1'b0;
  logic ready4Read, ready4Result, candidateValid, done, solidOriginal, windowError;
  logic [L*KW-1:0]  kmer;
  logic [L-1:0]     kmerValid;
  logic [2*RW-1:0]  candidate;
  logic [RBW-1:0]   candidatePosition;
  logic [KBW+1:0]   candidateCount;

  kmer_variant_generator #(
    .MAX_READ_BIT_WIDTH(RBW), .MAX_KMER_BIT_WIDTH(KBW), .QUALITY_WIDTH(QW),
    .LANES(L), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk), .rstb(rstb), .read(read), .quality(quality), .kmerLength(kmerLength),
    .kmerOffset(kmerOffset), .qualityThreshold(qualityThreshold), .readValid(readValid),
    .ready4Read(ready4Read), .kmer(kmer), .kmerValid(kmerValid), .ready4Kmer(ready4Kmer),
    .queryResultValid(queryResultValid), .queryResult(queryResult), .ready4Result(ready4Result),
    .candidate(candidate), .candidatePosition(candidatePosition), .candidateValid(candidateValid),
    .ready4Candidate(ready4Candidate), .done(done), .solidOriginal(solidOriginal),
    .candidateCount(candidateCount), .windowError(windowError)
  );

  always #5 clk = ~clk;

  typedef struct { logic [KW-1:0] km; bit orig; int idx; int p; int nb; } var_t;
  typedef struct { bit orig; bit solid; int p; int nb; } res_t;
  typedef struct { logic [2*RW-1:0] rd; int pos; } cand_t;

  var_t  exp_var[$];
  res_t  res_q[$];
  cand_t exp_cand[$];
  int passed = 0, total = 0;
  int g_groups, g_last_mask, g_issued, exp_count;
  bit exp_orig;
  logic [2*RW-1:0] cur_read;
  int cur_off, cur_mode, cur_sidx;
  bit cur_osolid;

  function automatic logic [KW-1:0] model_kmer(input logic [2*RW-1:0] r, input int off,
                                               input int k, input int p, input int a);
    logic [KW-1:0] w;
    logic [1:0] b;
    w = '0;
    for (int i = 0; i < k; i++) w[2*i +: 2] = r[2*(off+i) +: 2];
    if (p >= 0) begin
      b = w[2*p +: 2] + 2'(a);
      w[2*p +: 2] = b;
    end
    return w;
  endfunction

  function automatic bit pick_solid(input int idx);
    if (idx == 0 && cur_mode != 2) return cur_osolid;
    case (cur_mode)
      1:       return idx == cur_sidx;
      2:       return $urandom_range(0, 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2*RW-1:0] rand_vec();
    logic [2*RW-1:0] r;
    for (int i = 0; i < 2*RW/32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic run_read(input logic [2*RW-1:0] r, input logic [QW*RW-1:0] q, input int off,
                          input int k, input int thr, input int mode, input int sidx,
                          input bit osolid, input bit bp, input int hold, input int abort_after);
    bit err, cand_due, fin, elig;
    int cyc, hold_left, n;
    var_t v;
    res_t rs;
    cand_t c;
    logic [L-1:0] expm;
    exp_var.delete(); res_q.delete(); exp_cand.delete();
    exp_count = 0; exp_orig = 0; g_groups = 0; g_last_mask = 0; g_issued = 0;
    cur_read = r; cur_off = off; cur_mode = mode; cur_sidx = sidx; cur_osolid = osolid;
    err = (k == 0) || (off + k > RW);
    if (!err) begin
      v.km = model_kmer(r, off, k, -1, 0); v.orig = 1; v.idx = 0; v.p = 0; v.nb = 0;
      exp_var.push_back(v);
      for (int p = 0; p < k; p++) begin
        elig = 1'b1;
`ifdef KMER_QUALITY_GATE_EN
        elig = int'(q[QW*(off+p) +: QW]) < thr;
`endif
        for (int a = 1; a <= 3; a++) begin
          v.km = model_kmer(r, off, k, p, a); v.orig = 0; v.idx = 1 + 3*p + (a-1); v.p = p;
          v.nb = (int'(r[2*(off+p) +: 2]) + a) % 4;
          if (elig) exp_var.push_back(v);
        end
      end
    end
    cyc = 0;
    while (!ready4Read && cyc < 50) begin @(negedge clk); cyc++; end
    total++; if (ready4Read !== 1'b1) $display("FAIL read_accept_wait: ready4Read=%b want 1", ready4Read); else passed++;
    read = r; quality = q; kmerLength = KBW'(k); kmerOffset = RBW'(off);
    qualityThreshold = QW'(thr); readValid = 1'b1;
    @(negedge clk);
    readValid = 1'b0;
    cand_due = 0; fin = 0; hold_left = hold; cyc = 0;
    while (!fin && cyc < 4000) begin
      if (cyc > 0) @(negedge clk);
      if (abort_after > 0 && cyc == abort_after) return;
      ready4Kmer = bp ? ((cyc % 2) == 1) : 1'b1;
      if (candidateValid && hold_left > 0) begin ready4Candidate = 1'b0; hold_left--; end
      else ready4Candidate = 1'b1;
      if (res_q.size() > 0) begin queryResultValid = 1'b1; queryResult = res_q[0].solid; end
      else begin queryResultValid = 1'b0; queryResult = 1'b0; end
      #1;
      if (cyc == 0 && err) begin
        total++; if (done !== 1'b1) $display("FAIL werr_done_latency: done=%b want 1", done); else passed++;
      end
      if (cyc == 0 && !err) begin
        total++; if (kmerValid === '0) $display("FAIL issue_latency: kmerValid=%b want nonzero", kmerValid); else passed++;
      end
      if (err) begin
        total++; if (kmerValid !== '0) $display("FAIL werr_no_issue: kmerValid=%b want 0", kmerValid); else passed++;
      end
      if (cand_due) begin
        total++; if (candidateValid !== 1'b1) $display("FAIL cand_latency: candidateValid=%b want 1", candidateValid); else passed++;
        cand_due = 0;
      end
      if (candidateValid) begin
        total++; if (ready4Result !== 1'b0) $display("FAIL r4r_hold: ready4Result=%b want 0", ready4Result); else passed++;
      end
      if (ready4Kmer && kmerValid !== '0) begin
        g_groups++; g_last_mask = int'(kmerValid);
        n = 0;
        for (int j = 0; j < L; j++) if (kmerValid[j]) n++;
        expm = L'((1 << n) - 1);
        total++; if (kmerValid !== expm) $display("FAIL lane_pack: mask=%b want %b", kmerValid, expm); else passed++;
        for (int j = 0; j < n; j++) begin
          total++;
          if (exp_var.size() == 0) $display("FAIL extra_variant: lane %0d got %h want none", j, kmer[j*KW +: KW]);
          else begin
            v = exp_var.pop_front();
            if (kmer[j*KW +: KW] !== v.km) $display("FAIL variant_kmer idx %0d: got %h want %h", v.idx, kmer[j*KW +: KW], v.km);
            else passed++;
            rs.orig = v.orig; rs.solid = pick_solid(v.idx); rs.p = v.p; rs.nb = v.nb;
            res_q.push_back(rs); g_issued++;
          end
        end
      end
      if (queryResultValid && ready4Result) begin
        rs = res_q.pop_front();
        if (rs.orig) exp_orig = rs.solid;
        else if (rs.solid) begin
          c.rd = cur_read; c.rd[2*(cur_off+rs.p) +: 2] = 2'(rs.nb); c.pos = cur_off + rs.p;
          exp_cand.push_back(c); exp_count++; cand_due = 1;
        end
      end
      if (candidateValid && ready4Candidate) begin
        total++;
        if (exp_cand.size() == 0) $display("FAIL extra_candidate: pos=%0d want none", candidatePosition);
        else begin
          c = exp_cand.pop_front();
          if (candidate !== c.rd || candidatePosition !== RBW'(c.pos))
            $display("FAIL candidate: pos got %0d want %0d, read match=%b", candidatePosition, c.pos, candidate === c.rd);
          else passed++;
        end
      end
      if (done) begin
        total++; if (candidateCount !== (KBW+2)'(exp_count)) $display("FAIL cand_count: got %0d want %0d", candidateCount, exp_count); else passed++;
        total++; if (solidOriginal !== exp_orig) $display("FAIL solid_original: got %b want %b", solidOriginal, exp_orig); else passed++;
        total++; if (windowError !== err) $display("FAIL window_error: got %b want %b", windowError, err); else passed++;
        total++; if (exp_var.size() + exp_cand.size() + res_q.size() != 0)
          $display("FAIL leftovers: variants %0d candidates %0d results %0d want 0", exp_var.size(), exp_cand.size(), res_q.size());
        else passed++;
        fin = 1;
      end
      cyc++;
    end
    if (!fin) begin
      total++; $display("FAIL done_timeout: no done after %0d cycles", cyc);
    end else begin
      @(negedge clk);
      queryResultValid = 1'b0;
      total++; if (done !== 1'b0 || ready4Read !== 1'b1) $display("FAIL done_pulse: done=%b ready4Read=%b want 0/1", done, ready4Read); else passed++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    total++;
    if (kmerValid !== '0 || candidateValid !== 1'b0 || done !== 1'b0 || solidOriginal !== 1'b0 ||
        windowError !== 1'b0 || candidateCount !== '0 || kmer !== '0 || candidate !== '0 || ready4Read !== 1'b0)
      $display("FAIL %s: kv=%b cv=%b done=%b so=%b we=%b cc=%0d r4r=%b want all 0", tag, kmerValid,
               candidateValid, done, solidOriginal, windowError, candidateCount, ready4Read);
    else passed++;
  endtask

  task automatic test_reset();
    rstb = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_values");
    rstb = 1'b0;
    #1;
    total++; if (ready4Read !== 1'b1) $display("FAIL reset_release: ready4Read=%b want 1", ready4Read); else passed++;
  endtask

  task automatic test_all_zero();
    run_read('0, '0, 0, 4, 0, 0, 0, 0, 0, 0, 0);
    total++; if (g_issued != 13) $display("FAIL zero_issued: got %0d want 13", g_issued); else passed++;
    total++; if (g_groups != 7 || g_last_mask != 1) $display("FAIL zero_groups: groups %0d last %0d want 7/1", g_groups, g_last_mask); else passed++;
  endtask

  task automatic test_single_solid();
    logic [2*RW-1:0] r;
    r = rand_vec();
    r[13:12] = 2'b00;
    run_read(r, '0, 5, 3, 0, 1, 4, 1, 0, 0, 0);
    total++; if (g_issued != 10) $display("FAIL single_issued: got %0d want 10", g_issued); else passed++;
  endtask

  task automatic test_backpressure();
    run_read(rand_vec(), rand_vec(), 17, 8, 3, 2, 0, 0, 1, 10, 0);
  endtask

  task automatic test_window_error();
    run_read(rand_vec(), '0, 250, 10, 0, 2, 0, 0, 0, 0, 0);
    run_read(rand_vec(), '0, 3, 0, 0, 2, 0, 0, 0, 0, 0);
  endtask

  task automatic test_window_edge();
    run_read(rand_vec(), rand_vec(), 246, 10, 2, 2, 0, 0, 0, 0, 0);
    run_read(rand_vec(), rand_vec(), 193, 63, 3, 2, 0, 0, 1, 3, 0);
  endtask

  task automatic test_quality_gate();
    logic [QW*RW-1:0] q;
    int want;
    q = '0;
    q[7:0] = 8'b00_11_01_11;
    want = 13;
`ifdef KMER_QUALITY_GATE_EN
    want = 7;
`endif
    run_read(rand_vec(), q, 0, 4, 2, 2, 0, 0, 0, 0, 0);
    total++; if (g_issued != want) $display("FAIL gate_issued: got %0d want %0d", g_issued, want); else passed++;
  endtask

  task automatic test_back_to_back();
    run_read(rand_vec(), rand_vec(), 40, 5, 1, 2, 0, 0, 0, 0, 0);
    run_read(rand_vec(), rand_vec(), 41, 6, 2, 2, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    run_read(rand_vec(), '0, 10, 12, 0, 2, 0, 0, 0, 0, 4);
    rstb = 1'b1; ready4Kmer = 1'b0; queryResultValid = 1'b0; ready4Candidate = 1'b0;
    @(negedge clk);
    check_reset_vals("reset_mid");
    rstb = 1'b0;
    #1;
    total++; if (ready4Read !== 1'b1) $display("FAIL reset_mid_release: ready4Read=%b want 1", ready4Read); else passed++;
    run_read(rand_vec(), '0, 20, 6, 0, 2, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_single_solid();
    test_backpressure();
    test_window_error();
    test_window_edge();
    test_quality_gate();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
